multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multi-cycle control unit for the RISC-V RV32I core: the next generation after the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake with a bus-timeout watchdog. It adds unsigned branches, lui/auipc separation, illegal-instruction trapping and a retired-instruction counter. It sits between the instruction register/flags and the shared-memory multi-cycle datapath.

## Interface
- BUS_TIMEOUT, 16: maximum wait cycles for mem_ready; 0 disables the watchdog.
- TRAP_HALT, 1: 1 = TRAP holds until reset; 0 = TRAP lasts one cycle, then FETCH (the instruction is skipped).
- CNT_W, 32: width of the instret counter.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  7  instruction opcode from IR.
- funct3  in  3  instruction funct3 from IR.
- Zero, ALUR31, Carry  in  1 each  ALU flags: equal, signed-less-than, no-borrow (rs1>=rs2 unsigned).
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc  out  1 each  datapath strobes/selects.
- ResultSrc  out  2  00 ALUOut, 01 MemData, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero.
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- ALUOp  out  2  00 add, 01 subtract/compare, 10 funct decode.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- Store  out  2  00 sw, 01 sh, 10 sb.
- Load  out  3  funct3 of the load.
- Take_Branch  out  1  branch condition true.
- trap  out  1  controller is in TRAP.
- trap_cause  out  2  01 illegal, 10 bus timeout; held until the next trap or reset.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count; wraps to 0.

## Operation
- The state advances on the rising edge of clk. Outputs are decoded from state. FETCH, MEMREAD and MEMWRITE also gate on mem_ready.
- Unlisted outputs are 0 in every state. ImmSrc follows op in every state.
- FETCH: MemRead=1, AdrSrc=0. When mem_ready: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01 (ALUOut<=PC+imm). Next state by op:
  - 0000011 and 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - 0110111 and 0010111 → UPPER.
  - anything else → TRAP (cause 01).
- MEMADR: ALUSrcA=10, ALUSrcB=01.
  - Load → MEMREAD. Illegal load funct3 (011, 11x) → TRAP.
  - Store → MEMWRITE. Store funct3 other than 000/001/010 → TRAP.
- MEMREAD: AdrSrc=1, MemRead=1, Load=funct3. When mem_ready → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Load=funct3, retire → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, Store from funct3. When mem_ready: retire → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: same as EXECR but ALUSrcB=01 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Take_Branch, retire → FETCH. Take_Branch by funct3:
  - 000 Zero; 001 ~Zero.
  - 100 ALUR31; 101 ~ALUR31.
  - 110 ~Carry; 111 Carry.
  - 010/011: go to TRAP instead, with no PCWrite.
  - Take_Branch=0 in all other states.
- JALR: ALUSrcA=10, ALUSrcB=01 (ALUOut<=rs1+imm; the datapath clears bit 0) → JAL.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 → ALUWB (writes OldPC+4).
- UPPER: ALUSrcA=11 for lui, 01 for auipc; ALUSrcB=01 → ALUWB.
- TRAP: trap=1, all strobes 0. If TRAP_HALT=1, remain in TRAP; otherwise go to FETCH next cycle.
- Watchdog (BUS_TIMEOUT>0):
  - A counter clears on entry to FETCH/MEMREAD/MEMWRITE.
  - It increments each cycle in those states while mem_ready=0.
  - If mem_ready=0 while the count equals BUS_TIMEOUT-1, go to TRAP with cause 10.
  - mem_ready=1 in that same cycle wins: normal transition, no trap.
- retire increments instret in the same edge; at all-ones it wraps to 0.

## Timing
- Reset (async): state=FETCH, watchdog=0, instret=0, trap=0, trap_cause=00.
- While reset is high, PCWrite, IRWrite, RegWrite, MemRead and MemWrite are forced to 0.
- Latency with zero-wait memory:
  - R/I-ALU, lui/auipc: 4 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - jal: 4 cycles; jalr: 5 cycles.
- Each mem_ready wait cycle adds one cycle.
- mem_ready is only sampled in FETCH/MEMREAD/MEMWRITE; a request stays asserted until mem_ready.
- Reset mid-instruction aborts it: no retire, and no strobe after reset asserts.

## Test plan
- add x3,x1,x2 with mem_ready tied 1 → states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4, retire pulse in cycle 4, instret 0→1.
- lw with mem_ready delayed 3 cycles in MEMREAD → MemRead held 3 cycles. MEMWB follows with ResultSrc=01, Load=010. Total 8 cycles.
- bltu with Carry=0, then bgeu with Carry=0 → first has PCWrite=1/Take_Branch=1 in BRANCH; second has PCWrite=0. Both retire.
- op=0000000, TRAP_HALT=1 → TRAP after DECODE, trap=1, trap_cause=01. Remains in TRAP for 20 cycles with no strobes until reset.
- BUS_TIMEOUT=4, mem_ready held 0 in FETCH → TRAP on the 5th edge, cause 10. Repeat with mem_ready=1 on the 4th cycle → DECODE, no trap.
- CNT_W=4: retire 16 instructions → instret wraps 15→0. Assert reset mid-MEMWRITE → MemWrite drops immediately, state=FETCH, instret=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the RV32I multi-cycle controller and its datapath.
// master = controller side, slave = datapath/IR/memory side. CNT_W must match the controller's.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             Zero;
  logic             ALUR31;
  logic             Carry;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             AdrSrc;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [2:0]       ImmSrc;
  logic [1:0]       Store;
  logic [2:0]       Load;
  logic             Take_Branch;
  logic             trap;
  logic [1:0]       trap_cause;
  logic             retire;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct3, Zero, ALUR31, Carry, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Store, Load,
           Take_Branch, trap, trap_cause, retire, instret
  );

  modport slave (
    output op, funct3, Zero, ALUR31, Carry, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Store, Load,
           Take_Branch, trap, trap_cause, retire, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// RV32I multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// mem_ready handshake with bus watchdog, illegal-instruction trap and instret counter.
module multicycle_controller #(
  parameter int BUS_TIMEOUT = 16,
  parameter bit TRAP_HALT   = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_BUS = 2'b10;

  localparam int              WD_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP
  } state_t;

  state_t           state, state_nx;
  logic [WD_W-1:0]  wd_cnt;
  logic [1:0]       cause_q, cause_nx;
  logic [CNT_W-1:0] instret_q;

  logic       pc_wr, ir_wr, rf_wr, mem_rd, mem_wr, adr_src;
  logic [1:0] res_src, src_a, src_b, alu_op, store;
  logic [2:0] load, imm_src;
  logic       br_cond, take_br, trap_c, retire_c;
  logic       wait_st, timeout, ld_ok;

  assign wait_st = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout = (BUS_TIMEOUT > 0) && !bus.mem_ready && (wd_cnt == WD_LAST);
  assign ld_ok   = (bus.funct3 != 3'b011) && (bus.funct3[2:1] != 2'b11);

  always_comb begin
    imm_src = 3'b000;
    case (bus.op)
      OP_STORE:        imm_src = 3'b001;
      OP_BRANCH:       imm_src = 3'b010;
      OP_JAL:          imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:         imm_src = 3'b000;
    endcase
  end

  // Carry means rs1 >= rs2 unsigned, so bltu takes on ~Carry.
  always_comb begin
    br_cond = 1'b0;
    case (bus.funct3)
      3'b000:  br_cond = bus.Zero;
      3'b001:  br_cond = ~bus.Zero;
      3'b100:  br_cond = bus.ALUR31;
      3'b101:  br_cond = ~bus.ALUR31;
      3'b110:  br_cond = ~bus.Carry;
      3'b111:  br_cond = bus.Carry;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cause_nx = CAUSE_ILL;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    rf_wr    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    adr_src  = 1'b0;
    res_src  = 2'b00;
    src_a    = 2'b00;
    src_b    = 2'b00;
    alu_op   = 2'b00;
    store    = 2'b00;
    load     = 3'b000;
    take_br  = 1'b0;
    trap_c   = 1'b0;
    retire_c = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_wr    = 1'b1;
          pc_wr    = 1'b1;
          src_b    = 2'b10;
          res_src  = 2'b10;
          state_nx = S_DECODE;
        end else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXECR;
          OP_I:              state_nx = S_EXECI;
          OP_BRANCH:         state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_JALR:           state_nx = S_JALR;
          OP_LUI, OP_AUIPC:  state_nx = S_UPPER;
          default:           state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
        if (bus.op == OP_LOAD) state_nx = ld_ok ? S_MEMREAD : S_TRAP;
        else state_nx = (bus.funct3 <= 3'b010) ? S_MEMWRITE : S_TRAP;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_rd  = 1'b1;
        load    = bus.funct3;
        if (bus.mem_ready) state_nx = S_MEMWB;
        else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_BUS;
        end
      end
      S_MEMWB: begin
        res_src  = 2'b01;
        rf_wr    = 1'b1;
        load     = bus.funct3;
        retire_c = 1'b1;
        state_nx = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_wr  = 1'b1;
        case (bus.funct3[1:0])
          2'b00:   store = 2'b10;
          2'b01:   store = 2'b01;
          default: store = 2'b00;
        endcase
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          state_nx = S_FETCH;
        end else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_BUS;
        end
      end
      S_EXECR, S_EXECI: begin
        src_a    = 2'b10;
        src_b    = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_op   = 2'b10;
        state_nx = S_ALUWB;
      end
      S_ALUWB: begin
        rf_wr    = 1'b1;
        retire_c = 1'b1;
        state_nx = S_FETCH;
      end
      S_BRANCH: begin
        src_a  = 2'b10;
        alu_op = 2'b01;
        if (bus.funct3[2:1] == 2'b01) state_nx = S_TRAP;
        else begin
          take_br  = br_cond;
          pc_wr    = br_cond;
          retire_c = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_JALR: begin
        src_a    = 2'b10;
        src_b    = 2'b01;
        state_nx = S_JAL;
      end
      S_JAL: begin
        src_a    = 2'b01;
        src_b    = 2'b10;
        pc_wr    = 1'b1;
        state_nx = S_ALUWB;
      end
      S_UPPER: begin
        src_a    = (bus.op == OP_LUI) ? 2'b11 : 2'b01;
        src_b    = 2'b01;
        state_nx = S_ALUWB;
      end
      S_TRAP: begin
        trap_c   = 1'b1;
        state_nx = TRAP_HALT ? S_TRAP : S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      wd_cnt    <= '0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state <= state_nx;
      // Any state change (including TRAP->FETCH) restarts the watchdog.
      if (state_nx != state || !wait_st) wd_cnt <= '0;
      else if (!bus.mem_ready) wd_cnt <= wd_cnt + 1'b1;
      if (state_nx == S_TRAP && state != S_TRAP) cause_q <= cause_nx;
      if (retire_c) instret_q <= instret_q + 1'b1;
    end
  end

  // Reset state is FETCH, so strobes must be masked while reset is held.
  assign bus.PCWrite     = pc_wr & ~reset;
  assign bus.IRWrite     = ir_wr & ~reset;
  assign bus.RegWrite    = rf_wr & ~reset;
  assign bus.MemRead     = mem_rd & ~reset;
  assign bus.MemWrite    = mem_wr & ~reset;
  assign bus.retire      = retire_c & ~reset;
  assign bus.AdrSrc      = adr_src;
  assign bus.ResultSrc   = res_src;
  assign bus.ALUSrcA     = src_a;
  assign bus.ALUSrcB     = src_b;
  assign bus.ALUOp       = alu_op;
  assign bus.ImmSrc      = imm_src;
  assign bus.Store       = store;
  assign bus.Load        = load;
  assign bus.Take_Branch = take_br;
  assign bus.trap        = trap_c;
  assign bus.trap_cause  = cause_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expectations are queued at issue
// and checked when the controller retires (or traps).
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(4)) bus ();

  multicycle_controller #(.BUS_TIMEOUT(4), .TRAP_HALT(1'b1), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  typedef struct {
    string       tag;
    int          cyc;
    int          mr;
    logic [10:0] sig;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] cnt_m = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.retire};
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_rst_strobes"}, 32'(strobes()), 0);
    chk({tag, "_rst_trap"}, {30'd0, bus.trap, bus.trap_cause == 2'b00}, 1);
    chk({tag, "_rst_instret"}, 32'(bus.instret), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cnt_m = 4'd0;
  endtask

  // flg = {Zero, ALUR31, Carry}; fw/dw = mem_ready wait cycles on fetch/data access.
  // sig = {RegWrite, PCWrite, MemWrite, ResultSrc, Load, Store, Take_Branch} at retire.
  task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [2:0] flg, input int fw, input int dw,
                     input int cyc_e, input int mr_e, input logic [10:0] sig_e);
    exp_t e;
    int cyc = 0, mr = 0, f = fw, d = dw;
    bit done = 1'b0;
    logic [10:0] sig = '0;
    bus.op = op;
    bus.funct3 = f3;
    {bus.Zero, bus.ALUR31, bus.Carry} = flg;
    e.tag = tag; e.cyc = cyc_e; e.mr = mr_e; e.sig = sig_e;
    sbq.push_back(e);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.MemRead || bus.MemWrite) begin
        if (!bus.AdrSrc) begin bus.mem_ready = (f == 0); if (f > 0) f--; end
        else begin bus.mem_ready = (d == 0); if (d > 0) d--; end
      end else bus.mem_ready = 1'b1;
      #1;
      if (bus.MemRead) mr++;
      if (bus.retire) begin
        done = 1'b1;
        sig = {bus.RegWrite, bus.PCWrite, bus.MemWrite, bus.ResultSrc, bus.Load,
               bus.Store, bus.Take_Branch};
      end
    end
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (!done) chk({e.tag, "_retire"}, 0, 1);
    else begin
      cnt_m = cnt_m + 4'd1;
      chk({e.tag, "_cycles"}, cyc, e.cyc);
      chk({e.tag, "_memread"}, mr, e.mr);
      chk({e.tag, "_sig"}, 32'(sig), 32'(e.sig));
      chk({e.tag, "_instret"}, 32'(bus.instret), 32'(cnt_m));
    end
  endtask

  task automatic trap_case(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic rdy, input int n, input logic [1:0] cause, input int hold);
    bit bad = 1'b0;
    bus.op = op;
    bus.funct3 = f3;
    bus.mem_ready = rdy;
    for (int c = 1; c < n; c++) begin
      @(negedge clk);
      if (bus.trap || bus.retire) bad = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_pre_trap"}, 32'(bad), 0);
    chk({tag, "_trap"}, 32'(bus.trap), 1);
    chk({tag, "_cause"}, 32'(bus.trap_cause), 32'(cause));
    bad = 1'b0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (!bus.trap || strobes() != 6'd0) bad = 1'b1;
    end
    chk({tag, "_hold"}, 32'(bad), 0);
    chk({tag, "_hold_instret"}, 32'(bus.instret), 32'(cnt_m));
    do_reset(tag);
    chk({tag, "_cause_clr"}, 32'(bus.trap_cause), 0);
  endtask

  initial begin
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.mem_ready = 1'b1;
    bus.Zero = 1'b0; bus.ALUR31 = 1'b0; bus.Carry = 1'b0;
    #12;
    do_reset("init");

    run("add",   7'b0110011, 3'b000, 3'b000, 0, 0, 4, 1, 11'b100_00_000_00_0);
    run("lw_w3", 7'b0000011, 3'b010, 3'b000, 0, 3, 8, 5, 11'b100_01_010_00_0);
    run("bltu",  7'b1100011, 3'b110, 3'b000, 0, 0, 3, 1, 11'b010_00_000_00_1);
    run("bgeu",  7'b1100011, 3'b111, 3'b000, 0, 0, 3, 1, 11'b000_00_000_00_0);
    run("beq",   7'b1100011, 3'b000, 3'b100, 0, 0, 3, 1, 11'b010_00_000_00_1);
    run("bne",   7'b1100011, 3'b001, 3'b100, 0, 0, 3, 1, 11'b000_00_000_00_0);
    run("blt",   7'b1100011, 3'b100, 3'b010, 0, 0, 3, 1, 11'b010_00_000_00_1);
    run("sw",    7'b0100011, 3'b010, 3'b000, 0, 0, 4, 1, 11'b001_00_000_00_0);
    run("sb",    7'b0100011, 3'b000, 3'b000, 0, 0, 4, 1, 11'b001_00_000_10_0);
    run("sh_w2", 7'b0100011, 3'b001, 3'b000, 0, 2, 6, 1, 11'b001_00_000_01_0);
    run("lui",   7'b0110111, 3'b000, 3'b000, 0, 0, 4, 1, 11'b100_00_000_00_0);
    run("auipc", 7'b0010111, 3'b000, 3'b000, 0, 0, 4, 1, 11'b100_00_000_00_0);
    run("jal",   7'b1101111, 3'b000, 3'b000, 0, 0, 4, 1, 11'b100_00_000_00_0);
    run("jalr",  7'b1100111, 3'b000, 3'b000, 0, 0, 5, 1, 11'b100_00_000_00_0);
    run("addi",  7'b0010011, 3'b000, 3'b000, 0, 0, 4, 1, 11'b100_00_000_00_0);
    run("lbu",   7'b0000011, 3'b100, 3'b000, 0, 0, 5, 2, 11'b100_01_100_00_0);
    run("add_f3", 7'b0110011, 3'b000, 3'b000, 3, 0, 7, 4, 11'b100_00_000_00_0);

    trap_case("ill_op",  7'b0000000, 3'b000, 1'b1, 3, 2'b01, 20);
    trap_case("ill_ld",  7'b0000011, 3'b011, 1'b1, 4, 2'b01, 3);
    trap_case("ill_br",  7'b1100011, 3'b010, 1'b1, 4, 2'b01, 3);
    trap_case("bus_to",  7'b0110011, 3'b000, 1'b0, 5, 2'b10, 3);

    run("addi2", 7'b0010011, 3'b000, 3'b000, 0, 0, 4, 1, 11'b100_00_000_00_0);
    // Abort a store mid-MEMWRITE with reset.
    bus.op = 7'b0100011;
    bus.funct3 = 3'b000;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        if (bus.MemWrite) begin bus.mem_ready = 1'b0; seen = 1'b1; end
      end
      chk("abort_reach_mw", 32'(seen), 1);
    end
    @(negedge clk);
    chk("abort_mw_held", 32'(bus.MemWrite), 1);
    reset = 1'b1;
    #1;
    chk("abort_strobes", 32'(strobes()), 0);
    chk("abort_instret", 32'(bus.instret), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cnt_m = 4'd0;
    run("post_abort", 7'b0110011, 3'b000, 3'b000, 0, 0, 4, 1, 11'b100_00_000_00_0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
